// File: rtl/alu8_exec.sv
// Handshaked 8-bit execute stage: single-cycle logic/arithmetic, serial shifts
// at one bit per cycle, result and Z/N/C held until writeback accepts them.
module alu8_exec (
   input  logic       CLK,
   input  logic       RST,
   input  logic       IN_VALID,
   output logic       IN_READY,
   input  logic [2:0] OP,
   input  logic [7:0] A,
   input  logic [7:0] B,
   output logic       OUT_VALID,
   input  logic       OUT_READY,
   output logic [7:0] R,
   output logic       Z,
   output logic       N,
   output logic       C
);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t     state, state_next;
   logic [7:0] shift_reg;
   logic [2:0] shift_cnt;
   logic       shift_left;
   logic       accept;
   logic       start_shift;
   logic [7:0] alu_res;
   logic       alu_c;
   logic [8:0] sum9;
   logic [7:0] shift_next;
   logic       shift_out;

   assign IN_READY    = (state == IDLE);
   assign OUT_VALID   = (state == HOLD);
   assign accept      = IN_READY && IN_VALID;
   assign start_shift = (OP[2:1] == 2'b11) && (B[2:0] != 3'd0);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept) state_next = start_shift ? SHIFT : HOLD;
         SHIFT:   if (shift_cnt == 3'd1) state_next = HOLD;
         HOLD:    if (OUT_READY) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // SUB reuses the adder as A + ~B + 1, so the carry out means "no borrow"
   always_comb begin
      sum9    = {1'b0, A} + {1'b0, (OP[0] ? ~B : B)} + {8'd0, OP[0]};
      alu_res = A;
      alu_c   = 1'b0;
      unique case (OP)
         3'b000:  alu_res = A & B;
         3'b001:  alu_res = A | B;
         3'b010:  alu_res = A ^ B;
         3'b011:  alu_res = ~A;
         3'b100,
         3'b101:  begin alu_res = sum9[7:0]; alu_c = sum9[8]; end
         default: begin alu_res = A; alu_c = 1'b0; end
      endcase
   end

   always_comb begin
      shift_next = shift_left ? {shift_reg[6:0], 1'b0} : {1'b0, shift_reg[7:1]};
      shift_out  = shift_left ? shift_reg[7] : shift_reg[0];
   end

   // R only changes when a result completes; C tracks each bit shifted out
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         R          <= 8'h00;
         Z          <= 1'b0;
         N          <= 1'b0;
         C          <= 1'b0;
         shift_reg  <= 8'h00;
         shift_cnt  <= 3'd0;
         shift_left <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  if (start_shift) begin
                     shift_reg  <= A;
                     shift_cnt  <= B[2:0];
                     shift_left <= ~OP[0];
                  end else begin
                     R <= alu_res;
                     Z <= (alu_res == 8'h00);
                     N <= alu_res[7];
                     C <= alu_c;
                  end
               end
            end
            SHIFT: begin
               shift_reg <= shift_next;
               shift_cnt <= shift_cnt - 3'd1;
               C         <= shift_out;
               if (shift_cnt == 3'd1) begin
                  R <= shift_next;
                  Z <= (shift_next == 8'h00);
                  N <= shift_next[7];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/alu8_exec.md
# alu8_exec

Handshaked 8-bit execute stage of the EMU_v8-1 datapath. It sits between the instruction decoder and the accumulator/flag writeback. It latches an operation and two operands, then computes the result: logic and arithmetic ops finish in one cycle, and shifts run serially at one bit per cycle. It holds the result and the Z/N/C flags until writeback accepts them.

## Interface
Parameters:
- None. Datapath width is fixed at 8 bits and the shift count at 3 bits.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- IN_VALID  in  1  the decoder presents OP/A/B.
- IN_READY  out  1  the stage can accept; equals (state == IDLE).
- OP  in  3  operation select.
- A  in  8  operand A.
- B  in  8  operand B; for shifts, B[2:0] is the shift count.
- OUT_VALID  out  1  R/Z/N/C hold a completed result.
- OUT_READY  in  1  writeback consumes the result.
- R  out  8  registered result.
- Z  out  1  registered zero flag, (R == 0).
- N  out  1  registered negative flag, R[7].
- C  out  1  registered carry flag.

## Operation
- Op encoding:
  - 000 AND: R = A & B.
  - 001 OR: R = A | B.
  - 010 XOR: R = A ^ B.
  - 011 NOT: R = ~A.
  - 100 ADD: R = A + B.
  - 101 SUB: R = A - B.
  - 110 SHL: A shifted left by B[2:0].
  - 111 SHR: logical shift right of A by B[2:0].
- Arithmetic is 8-bit modulo 256.
  - ADD: C = carry out of bit 7.
  - SUB: computed as A + ~B + 1; C = 1 iff A >= B (unsigned, no borrow).
- Logic ops (000–011): C = 0.
- Shifts:
  - C = the last bit shifted out.
  - Vacated bits are filled with 0.
  - With a count of 0: R = A and C = 0.
- Z and N are always derived from the final R.
- States:
  - IDLE: IN_READY = 1, OUT_VALID = 0.
  - SHIFT: serial shift in progress; IN_READY = 0, OUT_VALID = 0.
  - HOLD: OUT_VALID = 1, IN_READY = 0.
- Accept occurs on a rising edge with IN_VALID & IN_READY. OP, A and B are sampled only at accept; they are ignored at all other times.
- IDLE transitions on accept:
  - OP 000–101: R/Z/N/C are loaded with the final values, and the state goes to HOLD.
  - OP 110/111 with count = 0: R = A, C = 0, go to HOLD.
  - OP 110/111 with count n > 0: load the shift register with A and the counter with n, go to SHIFT.
- SHIFT, each edge:
  - Shift one bit in the selected direction.
  - C = the bit shifted out.
  - Decrement the counter.
  - When the counter reaches 0, Z and N are updated in the same edge and the state goes to HOLD.
- HOLD:
  - On an edge with OUT_READY = 1, go to IDLE.
  - Otherwise R/Z/N/C/OUT_VALID stay stable.
  - R/Z/N/C are not cleared on leaving HOLD; they keep their last values.
- The stage never overlaps operations: no new accept happens until the result has drained. There is no combinational path from IN_VALID to OUT_VALID, or from OUT_READY to IN_READY.

## Timing
- Reset values: state = IDLE, R = 0x00, Z = 0, N = 0, C = 0, OUT_VALID = 0, shift counter = 0.
- IN_READY is 1 while RST is high, but IN_VALID is ignored during reset.
- RST asserted mid-SHIFT or mid-HOLD: the operation is aborted immediately. No result is emitted and all outputs take their reset values.
- Latency from the accept edge to OUT_VALID high:
  - 1 edge for OP 000–101 and for shifts by 0.
  - n + 1 edges for a shift by n, so 8 edges maximum for n = 7.
- Throughput: one operation per (latency + 1) cycles at best, because IDLE is revisited between operations.
- OUT_READY held high in HOLD: exactly one edge in HOLD, then IDLE.
- OUT_READY high outside HOLD: no effect.
- IN_VALID held high while not IDLE: no effect; the pending request is accepted on the first IDLE edge.

## Test plan
- Reset, then OP = 000, A = 0xF0, B = 0x3C → next cycle OUT_VALID = 1, R = 0x30, Z = 0, N = 0, C = 0; IN_READY = 0 until OUT_READY.
- ADD 0xFF + 0x01 → R = 0x00, Z = 1, C = 1. Then SUB 0x05 − 0x07 → R = 0xFE, N = 1, C = 0.
- SHL A = 0x81, B = 0x03 → OUT_VALID rises 4 edges after accept, R = 0x08, C = 0. Also SHR A = 0x81, B = 0x01 → R = 0x40, C = 1 after 2 edges.
- Shift by 0 with A = 0x55 → R = 0x55, C = 0, 1-edge latency. Also shift by 7 → 8-edge latency.
- Backpressure: hold OUT_READY = 0 for 5 cycles in HOLD with IN_VALID = 1 and changing A/B → R/flags stay stable, no second accept; release → IDLE, next request accepted.
- Assert RST during the 3rd cycle of a SHL by 7 → OUT_VALID = 0 and R = 0x00 immediately, state IDLE after release, no stale result appears.
